// File: rtl/game_control_fsm.sv
// game_control_fsm
//   Top-level game sequencer. The lanes are held in reset while idle or after
//   a game over. Per-lane success pulses add points through a one-cycle POINT
//   state, which also advances the difficulty level. A game ends when any lane
//   reports failure.
//
//   Optional feature macro: BEST_SCORE_EN compiles in the best-score record.
//   Without it, best_score and new_best are tied to 0.
//
//   state | meaning
//   IDLE  | lanes in reset, score/level cleared, waiting for a start press
//   RUN   | game running, watching game_over / correct
//   POINT | one cycle: add the latched hit count to score and level counter
//   OVER  | game finished, score held, waiting for a start press
//
// Ports
//   clock        in   rising-edge system clock
//   reset_button in   asynchronous active-high reset
//   start_button in   player start request (level signal)
//   game_over    in   per-lane failure pulse  [NUM_LANES]
//   correct      in   per-lane success pulse  [NUM_LANES]
//   reset_signal out  high while the lanes are held in reset
//   score        out  current score          [SCORE_W]
//   best_score   out  best completed score   [SCORE_W]
//   level        out  current level          [3]
//   new_best     out  last game set a record (valid in OVER)
//   state        out  current FSM state code [3]
module game_control_fsm #(
  parameter int NUM_LANES  = 3,
  parameter int SCORE_W    = 8,
  parameter int LEVEL_STEP = 10,
  parameter int MAX_LEVEL  = 7
) (
  input  logic                 clock,
  input  logic                 reset_button,
  input  logic                 start_button,
  input  logic [NUM_LANES-1:0] game_over,
  input  logic [NUM_LANES-1:0] correct,
  output logic                 reset_signal,
  output logic [SCORE_W-1:0]   score,
  output logic [SCORE_W-1:0]   best_score,
  output logic [2:0]           level,
  output logic                 new_best,
  output logic [2:0]           state
);

  localparam int CNT_W = $clog2(NUM_LANES + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    RUN   = 3'b001,
    POINT = 3'b010,
    OVER  = 3'b011
  } state_e;

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [2:0]         level_q, level_d;
  logic [7:0]         lvl_pts_q, lvl_pts_d;
  logic [CNT_W-1:0]   pts_q, pts_d;
  logic               reset_signal_q, reset_signal_d;
  logic               start_d;
  logic               start_evt;
  logic [CNT_W-1:0]   pop;
  logic [SCORE_W:0]   score_sum;
  logic [8:0]         lvl_sum;

  assign start_evt = start_button & ~start_d;

  always_ff @(posedge clock or posedge reset_button) begin
    if (reset_button) begin
      state_q        <= IDLE;
      score_q        <= '0;
      level_q        <= '0;
      lvl_pts_q      <= '0;
      pts_q          <= '0;
      reset_signal_q <= 1'b1;
      // Seeded high so a button already held during reset is not seen as a
      // press; the player has to release and press again.
      start_d        <= 1'b1;
    end else begin
      state_q        <= state_d;
      score_q        <= score_d;
      level_q        <= level_d;
      lvl_pts_q      <= lvl_pts_d;
      pts_q          <= pts_d;
      reset_signal_q <= reset_signal_d;
      start_d        <= start_button;
    end
  end

  always_comb begin
    state_d   = state_q;
    score_d   = score_q;
    level_d   = level_q;
    lvl_pts_d = lvl_pts_q;
    pts_d     = pts_q;

    pop = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      pop = pop + CNT_W'(correct[i]);
    end

    score_sum = {1'b0, score_q} + (SCORE_W + 1)'(pts_q);
    lvl_sum   = {1'b0, lvl_pts_q} + 9'(pts_q);

    case (state_q)
      IDLE: begin
        score_d   = '0;
        level_d   = '0;
        lvl_pts_d = '0;
        if (start_evt) state_d = RUN;
      end
      RUN: begin
        if (|game_over) begin
          state_d = OVER;
        end else if (|correct) begin
          pts_d   = pop;
          state_d = POINT;
        end
      end
      POINT: begin
        score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
        // lvl_pts stays below LEVEL_STEP, so one subtraction is enough.
        if (lvl_sum >= 9'(LEVEL_STEP)) begin
          lvl_pts_d = 8'(lvl_sum - 9'(LEVEL_STEP));
          if (level_q < 3'(MAX_LEVEL)) level_d = level_q + 3'd1;
        end else begin
          lvl_pts_d = lvl_sum[7:0];
        end
        state_d = RUN;
      end
      OVER: begin
        if (start_evt) begin
          state_d   = IDLE;
          score_d   = '0;
          level_d   = '0;
          lvl_pts_d = '0;
        end
      end
      default: begin
        state_d   = IDLE;
        score_d   = '0;
        level_d   = '0;
        lvl_pts_d = '0;
      end
    endcase

    reset_signal_d = !(state_d == RUN || state_d == POINT);
  end

`ifdef BEST_SCORE_EN
  logic [SCORE_W-1:0] best_q;
  logic               new_best_q;

  // Score is stable in RUN, so comparing on the RUN->OVER edge samples the
  // final score exactly once.
  always_ff @(posedge clock or posedge reset_button) begin
    if (reset_button) begin
      best_q     <= '0;
      new_best_q <= 1'b0;
    end else if (state_q == RUN && |game_over) begin
      if (score_q > best_q) begin
        best_q     <= score_q;
        new_best_q <= 1'b1;
      end
    end else if (state_q == OVER && start_evt) begin
      new_best_q <= 1'b0;
    end
  end

  assign best_score = best_q;
  assign new_best   = new_best_q;
`else
  assign best_score = '0;
  assign new_best   = 1'b0;
`endif

  assign state        = state_q;
  assign score        = score_q;
  assign level        = level_q;
  assign reset_signal = reset_signal_q;

endmodule

// File: tb/tb_game_control_fsm.sv
// Testbench for game_control_fsm. A scoreboard holds the expected output
// snapshot for every state transition; a monitor compares on each transition.
// A second instance with SCORE_W=4 shares the stimulus to show saturation.
module tb_game_control_fsm;

`ifdef BEST_SCORE_EN
  localparam bit BEST_EN = 1'b1;
`else
  localparam bit BEST_EN = 1'b0;
`endif

  localparam logic [2:0] S_IDLE  = 3'b000;
  localparam logic [2:0] S_RUN   = 3'b001;
  localparam logic [2:0] S_POINT = 3'b010;
  localparam logic [2:0] S_OVER  = 3'b011;

  logic       clock, reset_button, start_button;
  logic [2:0] game_over, correct;
  logic       reset_signal, new_best;
  logic [7:0] score, best_score;
  logic [2:0] level, state;
  logic       rs4, nb4;
  logic [3:0] score4, best4;
  logic [2:0] level4, state4;

  game_control_fsm dut (
    .clock(clock), .reset_button(reset_button), .start_button(start_button),
    .game_over(game_over), .correct(correct), .reset_signal(reset_signal),
    .score(score), .best_score(best_score), .level(level),
    .new_best(new_best), .state(state)
  );

  game_control_fsm #(.SCORE_W(4)) dut4 (
    .clock(clock), .reset_button(reset_button), .start_button(start_button),
    .game_over(game_over), .correct(correct), .reset_signal(rs4),
    .score(score4), .best_score(best4), .level(level4),
    .new_best(nb4), .state(state4)
  );

  typedef struct {
    logic [2:0] st;
    logic [7:0] sc;
    logic [2:0] lv;
    logic       rs;
    logic [7:0] bs;
    logic       nb;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cur_sc = 0, cur_lv = 0, cur_best = 0;
  logic [2:0] prev_st;
  bit   mon_en = 1'b0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin : monitor
    exp_t e;
    if (mon_en && state !== prev_st) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_transition state=%0d prev=%0d score=%0d", state, prev_st, score);
      end else begin
        e = sb.pop_front();
        if ({state, score, level, reset_signal, best_score, new_best} !==
            {e.st, e.sc, e.lv, e.rs, e.bs, e.nb}) begin
          n_fail++;
          $display("FAIL transition actual st=%0d sc=%0d lv=%0d rs=%0d best=%0d nb=%0d required st=%0d sc=%0d lv=%0d rs=%0d best=%0d nb=%0d",
                   state, score, level, reset_signal, best_score, new_best,
                   e.st, e.sc, e.lv, e.rs, e.bs, e.nb);
        end
      end
      prev_st = state;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push(input logic [2:0] st, input int sc, input int lv,
                      input bit rs, input int bs, input bit nb);
    exp_t e;
    e.st = st;
    e.sc = 8'(sc);
    e.lv = 3'(lv);
    e.rs = rs;
    e.bs = BEST_EN ? 8'(bs) : 8'd0;
    e.nb = BEST_EN ? nb : 1'b0;
    sb.push_back(e);
  endtask

  task automatic start_game();
    start_button = 1'b1;
    push(S_RUN, 0, 0, 1'b0, cur_best, 1'b0);
    tick();
    start_button = 1'b0;
    tick();
  endtask

  // sc_after / lv_after are the hand-computed score and level once POINT ends.
  task automatic do_correct(input logic [2:0] v, input int sc_after, input int lv_after);
    correct = v;
    push(S_POINT, cur_sc, cur_lv, 1'b0, cur_best, 1'b0);
    tick();
    correct = 3'b000;
    push(S_RUN, sc_after, lv_after, 1'b0, cur_best, 1'b0);
    tick();
    cur_sc = sc_after;
    cur_lv = lv_after;
  endtask

  task automatic end_game(input logic [2:0] gov, input logic [2:0] cor, input bit exp_nb);
    game_over = gov;
    correct   = cor;
    if (exp_nb) cur_best = cur_sc;
    push(S_OVER, cur_sc, cur_lv, 1'b1, cur_best, exp_nb);
    tick();
    game_over = 3'b000;
    correct   = 3'b000;
    tick();
    chk("over_hold_score", int'(score), cur_sc);
    start_button = 1'b1;
    push(S_IDLE, 0, 0, 1'b1, cur_best, 1'b0);
    tick();
    tick();
    tick();
    chk("idle_held_start_state", int'(state), int'(S_IDLE));
    chk("idle_score", int'(score), 0);
    start_button = 1'b0;
    tick();
    cur_sc = 0;
    cur_lv = 0;
  endtask

  initial begin
    reset_button = 1'b1;
    start_button = 1'b0;
    game_over    = 3'b000;
    correct      = 3'b000;
    repeat (3) tick();
    reset_button = 1'b0;
    chk("rst_state", int'(state), int'(S_IDLE));
    chk("rst_reset_signal", int'(reset_signal), 1);
    chk("rst_score", int'(score), 0);
    chk("rst_best", int'(best_score), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_new_best", int'(new_best), 0);
    prev_st = state;
    mon_en  = 1'b1;
    tick();

    // Game 1: one hit, then failure and hit together (failure wins).
    start_game();
    do_correct(3'b001, 1, 0);
    end_game(3'b010, 3'b111, 1'b1);

    // Game 2: ends equal to best -> no record.
    start_game();
    do_correct(3'b001, 1, 0);
    end_game(3'b001, 3'b000, 1'b0);

    // Game 3: start press mid-game ignored; triples drive level and saturation.
    start_game();
    start_button = 1'b1;
    tick();
    start_button = 1'b0;
    tick();
    do_correct(3'b111, 3, 0);
    do_correct(3'b111, 6, 0);
    do_correct(3'b111, 9, 0);
    do_correct(3'b111, 12, 1);
    chk("lvl_pts_after_12", int'(dut.lvl_pts_q), 2);
    chk("level_after_12", int'(level), 1);
    do_correct(3'b111, 15, 1);
    do_correct(3'b111, 18, 1);
    chk("score4_saturated", int'(score4), 15);
    chk("lvl_pts_after_18", int'(dut.lvl_pts_q), 8);
    end_game(3'b100, 3'b000, 1'b1);

    // Game 4: lower score keeps the old record.
    start_game();
    do_correct(3'b011, 2, 0);
    do_correct(3'b001, 3, 0);
    end_game(3'b100, 3'b000, 1'b0);
    chk("best_kept", int'(best_score), BEST_EN ? 18 : 0);

    // Game 5: asynchronous reset while in POINT with score 9.
    start_game();
    do_correct(3'b111, 3, 0);
    do_correct(3'b111, 6, 0);
    do_correct(3'b111, 9, 0);
    correct = 3'b111;
    push(S_POINT, 9, 0, 1'b0, cur_best, 1'b0);
    tick();
    correct = 3'b000;
    chk("point_score_9", int'(score), 9);
    @(negedge clock);
    #1;
    cur_best = 0;
    push(S_IDLE, 0, 0, 1'b1, 0, 1'b0);
    start_button = 1'b1;
    reset_button = 1'b1;
    #1;
    chk("async_state", int'(state), int'(S_IDLE));
    chk("async_reset_signal", int'(reset_signal), 1);
    chk("async_score", int'(score), 0);
    chk("async_best", int'(best_score), 0);
    chk("async_level", int'(level), 0);
    chk("async_new_best", int'(new_best), 0);
    tick();
    reset_button = 1'b0;
    repeat (3) tick();
    chk("held_start_after_reset", int'(state), int'(S_IDLE));
    start_button = 1'b0;
    tick();
    start_game();
    chk("restart_state", int'(state), int'(S_RUN));
    tick();
    chk("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
